// File: rtl/pio_edge_servicer_if.sv
// Avalon-MM bus between the edge servicer (master) and the edge-capture PIO (slave).
// The slave's level interrupt travels with the bus.
interface pio_edge_servicer_if;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        irq;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata, irq
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata, irq
  );
endinterface

// File: rtl/pio_edge_servicer.sv
// Services an edge-capture PIO on irq and queues {capture,data[,time]} events in a FIFO.
// Define PIO_EDGE_SERVICER_TIMESTAMP_EN to timestamp each event with a 16-bit cycle counter.
module pio_edge_servicer #(
  parameter int              DATA_W       = 8,
  parameter int              READ_LATENCY = 1,
  parameter int              FIFO_DEPTH   = 4,
  parameter logic [DATA_W-1:0] MASK_INIT  = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pio_edge_servicer_if.master    avm,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [DATA_W-1:0]      evt_capture,
  output logic [DATA_W-1:0]      evt_data,
  output logic [15:0]            evt_time,
  output logic                   overflow,
  input  logic                   overflow_clr,
  output logic                   busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MASK = 2'd2;
  localparam logic [1:0] A_CAP  = 2'd3;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_RD_CAP, S_WAIT_CAP, S_CLR,
    S_RD_DATA, S_WAIT_DATA, S_PUSH, S_HOLD
  } state_t;

  state_t                state_q;
  logic [1:0]            addr_q;
  logic                  cs_q;
  logic                  wr_n_q;
  logic [31:0]           wdata_q;
  logic [DATA_W-1:0]     cap_q;
  logic [DATA_W-1:0]     dat_q;
  logic                  busy_q;
  // Bit 0 marks the cycle a read is on the bus; bit READ_LATENCY marks the sample cycle.
  logic [READ_LATENCY:0] vld_pipe_q;

  logic [DATA_W-1:0]     rd_lo;
  logic                  rd_done;
  logic                  unused_rd_hi;

  assign rd_lo        = avm.avm_readdata[DATA_W-1:0];
  assign rd_done      = vld_pipe_q[READ_LATENCY];
  assign unused_rd_hi = ^avm.avm_readdata[31:DATA_W];

  assign avm.avm_address    = addr_q;
  assign avm.avm_chipselect = cs_q;
  assign avm.avm_write_n    = wr_n_q;
  assign avm.avm_writedata  = wdata_q;
  assign busy               = busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_INIT;
      addr_q     <= '0;
      cs_q       <= 1'b0;
      wr_n_q     <= 1'b1;
      wdata_q    <= '0;
      cap_q      <= '0;
      dat_q      <= '0;
      busy_q     <= 1'b1;
      vld_pipe_q <= '0;
    end else begin
      cs_q       <= 1'b0;
      wr_n_q     <= 1'b1;
      vld_pipe_q <= {vld_pipe_q[READ_LATENCY-1:0], 1'b0};
      case (state_q)
        S_INIT: begin
          cs_q    <= 1'b1;
          wr_n_q  <= 1'b0;
          addr_q  <= A_MASK;
          wdata_q <= 32'(MASK_INIT);
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        S_IDLE: begin
          if (avm.irq) begin
            state_q <= S_RD_CAP;
            busy_q  <= 1'b1;
          end
        end
        S_RD_CAP: begin
          cs_q       <= 1'b1;
          addr_q     <= A_CAP;
          vld_pipe_q <= {vld_pipe_q[READ_LATENCY-1:0], 1'b1};
          state_q    <= S_WAIT_CAP;
        end
        S_WAIT_CAP: begin
          if (rd_done) begin
            cap_q   <= rd_lo;
            // An all-zero capture is spurious: no clear write, no event.
            state_q <= (rd_lo == '0) ? S_HOLD : S_CLR;
          end
        end
        S_CLR: begin
          cs_q    <= 1'b1;
          wr_n_q  <= 1'b0;
          addr_q  <= A_CAP;
          wdata_q <= 32'(cap_q);
          state_q <= S_RD_DATA;
        end
        S_RD_DATA: begin
          cs_q       <= 1'b1;
          addr_q     <= A_DATA;
          vld_pipe_q <= {vld_pipe_q[READ_LATENCY-1:0], 1'b1};
          state_q    <= S_WAIT_DATA;
        end
        S_WAIT_DATA: begin
          if (rd_done) begin
            dat_q   <= rd_lo;
            state_q <= S_PUSH;
          end
        end
        S_PUSH: state_q <= S_HOLD;
        // Gives the slave a cycle to drop irq after the clear before IDLE looks again.
        S_HOLD: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_INIT;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       cnt_q;
  logic [DATA_W-1:0] cap_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] dat_mem [FIFO_DEPTH];
  logic              push, pop, accept, drop;

  assign push      = (state_q == S_PUSH);
  assign evt_valid = (cnt_q != '0);
  assign pop       = evt_valid && evt_ready;
  // A same-cycle pop frees a slot, so a full FIFO still accepts.
  assign accept    = push && ((cnt_q < (AW+1)'(FIFO_DEPTH)) || pop);
  assign drop      = push && !accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        cap_mem[i] <= '0;
        dat_mem[i] <= '0;
      end
    end else begin
      if (accept) begin
        cap_mem[wr_ptr_q] <= cap_q;
        dat_mem[wr_ptr_q] <= dat_q;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({accept, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  assign evt_capture = evt_valid ? cap_mem[rd_ptr_q] : '0;
  assign evt_data    = evt_valid ? dat_mem[rd_ptr_q] : '0;

`ifdef PIO_EDGE_SERVICER_TIMESTAMP_EN
  logic [15:0] ts_q;
  logic [15:0] tcap_q;
  logic [15:0] time_mem [FIFO_DEPTH];

  // Stamp taken at the capture sample, so it tracks edge detection rather than queueing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q   <= '0;
      tcap_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) time_mem[i] <= '0;
    end else begin
      ts_q <= ts_q + 16'd1;
      if (state_q == S_WAIT_CAP && rd_done) tcap_q <= ts_q;
      if (accept) time_mem[wr_ptr_q] <= tcap_q;
    end
  end

  assign evt_time = evt_valid ? time_mem[rd_ptr_q] : '0;
`else
  assign evt_time = 16'h0000;
`endif

endmodule

// File: tb/tb_pio_edge_servicer.sv
// Directed bench for pio_edge_servicer against a behavioural edge-capture PIO slave.
module tb_pio_edge_servicer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [7:0]  evt_capture, evt_data;
  logic [15:0] evt_time;
  logic        overflow;
  logic        overflow_clr = 1'b0;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pio_edge_servicer_if bus();

  pio_edge_servicer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .avm          (bus),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_capture  (evt_capture),
    .evt_data     (evt_data),
    .evt_time     (evt_time),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .busy         (busy)
  );

  // Slave model: capture ORs in new edges, any write to addr 3 clears all bits.
  logic [7:0] s_cap = 8'h00, s_mask = 8'h00, s_data = 8'h00, edge_set = 8'h00;
  logic       irq_force = 1'b0;
  assign bus.irq = (|(s_cap & s_mask)) | irq_force;

  function automatic logic [7:0] rd_mux(input logic [1:0] a);
    case (a)
      2'd0:    return s_data;
      2'd2:    return s_mask;
      2'd3:    return s_cap;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd2)
      s_mask <= bus.avm_writedata[7:0];
    if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd3)
      s_cap <= 8'h00;
    else
      s_cap <= s_cap | edge_set;
    if (bus.avm_chipselect && bus.avm_write_n)
      bus.avm_readdata <= {24'hA5A5A5, rd_mux(bus.avm_address)};
  end

  // Bus log entries are {is_write, address}.
  logic [2:0]  bus_log[$];
  logic [31:0] last_wd = 32'h0;
  always @(posedge clk) begin
    if (bus.avm_chipselect) begin
      bus_log.push_back({~bus.avm_write_n, bus.avm_address});
      if (!bus.avm_write_n) last_wd <= bus.avm_writedata;
    end
  end

  function automatic logic [11:0] log_seq();
    logic [11:0] s = '0;
    foreach (bus_log[i]) s = {s[8:0], bus_log[i]};
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic lvl, input int max, output bit ok);
    ok = (busy === lvl);
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      ok = (busy === lvl);
    end
  endtask

  task automatic fire(input logic [7:0] c, input logic [7:0] d, output bit ok);
    bit ok1, ok2;
    s_data   = d;
    edge_set = c;
    tick();
    edge_set = 8'h00;
    wait_busy(1'b1, 5, ok1);
    wait_busy(1'b0, 40, ok2);
    ok = ok1 && ok2;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    n_vec++; if (bus.avm_chipselect !== 1'b0) begin n_err++; $display("FAIL rst_cs got %b exp 0", bus.avm_chipselect); end
    n_vec++; if (bus.avm_write_n !== 1'b1) begin n_err++; $display("FAIL rst_write_n got %b exp 1", bus.avm_write_n); end
    n_vec++; if (bus.avm_address !== 2'd0) begin n_err++; $display("FAIL rst_addr got %0d exp 0", bus.avm_address); end
    n_vec++; if (bus.avm_writedata !== 32'h0) begin n_err++; $display("FAIL rst_wdata got %h exp 0", bus.avm_writedata); end
    n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL rst_evt_valid got %b exp 0", evt_valid); end
    n_vec++; if ({evt_capture, evt_data, evt_time} !== 32'h0) begin n_err++; $display("FAIL rst_evt got %h exp 0", {evt_capture, evt_data, evt_time}); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow got %b exp 0", overflow); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_busy got %b exp 1", busy); end
    reset_n = 1'b1;
    tick();
    n_vec++; if ({bus.avm_chipselect, bus.avm_write_n, bus.avm_address} !== 4'b1010) begin n_err++; $display("FAIL init_write cs/wn/addr got %b exp 1010", {bus.avm_chipselect, bus.avm_write_n, bus.avm_address}); end
    n_vec++; if (bus.avm_writedata !== 32'hFF) begin n_err++; $display("FAIL init_wdata got %h exp 000000ff", bus.avm_writedata); end
    tick();
    n_vec++; if ({bus.avm_chipselect, busy} !== 2'b00) begin n_err++; $display("FAIL init_idle cs/busy got %b exp 00", {bus.avm_chipselect, busy}); end
    n_vec++; if (s_mask !== 8'hFF) begin n_err++; $display("FAIL init_mask got %h exp ff", s_mask); end
  endtask

  task automatic test_event();
    bit ok;
    bus_log.delete();
    fire(8'h04, 8'h5A, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL evt_timeout got busy=%b exp 0", busy); end
    n_vec++; if (bus_log.size() != 3 || log_seq() !== 12'b000_011_111_000) begin n_err++; $display("FAIL evt_bus_seq got n=%0d seq=%b exp n=3 seq=011111000", bus_log.size(), log_seq()); end
    n_vec++; if (last_wd !== 32'h04) begin n_err++; $display("FAIL evt_clr_wdata got %h exp 00000004", last_wd); end
    n_vec++; if ({evt_valid, evt_capture, evt_data} !== {1'b1, 8'h04, 8'h5A}) begin n_err++; $display("FAIL evt_head got v=%b c=%h d=%h exp v=1 c=04 d=5a", evt_valid, evt_capture, evt_data); end
    n_vec++; if (s_cap !== 8'h00) begin n_err++; $display("FAIL evt_slave_cleared got %h exp 00", s_cap); end
`ifndef PIO_EDGE_SERVICER_TIMESTAMP_EN
    n_vec++; if (evt_time !== 16'h0) begin n_err++; $display("FAIL evt_time_tied got %h exp 0000", evt_time); end
`endif
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL evt_pop got v=%b exp 0", evt_valid); end
  endtask

  task automatic test_overflow();
    bit ok;
    for (int i = 0; i < 5; i++) begin
      fire(8'(1 << i), 8'(8'h10 + i), ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL ovf_timeout ev=%0d got busy=%b exp 0", i, busy); end
      if (i == 3) begin
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b exp 0", overflow); end
      end
    end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b exp 1", overflow); end
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr got %b exp 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if ({evt_valid, evt_capture, evt_data} !== {1'b1, 8'(1 << i), 8'(8'h10 + i)}) begin n_err++; $display("FAIL ovf_drain%0d got v=%b c=%h d=%h exp v=1 c=%h d=%h", i, evt_valid, evt_capture, evt_data, 8'(1 << i), 8'(8'h10 + i)); end
      evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    end
    n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL ovf_fifth_dropped got v=%b exp 0", evt_valid); end
  endtask

  task automatic test_full_pop();
    bit ok;
    logic [7:0] caps [5];
    caps = '{8'h11, 8'h22, 8'h44, 8'h88, 8'h55};
    for (int i = 0; i < 4; i++) fire(caps[i], 8'(8'h20 + i), ok);
    s_data = 8'h99; edge_set = caps[4];
    tick();
    edge_set = 8'h00;
    // capture-path timing puts PUSH eight cycles after the edge lands
    repeat (8) tick();
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_no_drop got ovf=%b exp 0", overflow); end
    n_vec++; if (evt_capture !== 8'h22) begin n_err++; $display("FAIL fullpop_head got %h exp 22", evt_capture); end
    wait_busy(1'b0, 10, ok);
    for (int i = 1; i < 5; i++) begin
      n_vec++; if ({evt_valid, evt_capture} !== {1'b1, caps[i]}) begin n_err++; $display("FAIL fullpop_drain%0d got v=%b c=%h exp v=1 c=%h", i, evt_valid, evt_capture, caps[i]); end
      evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    end
    n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL fullpop_empty got v=%b exp 0", evt_valid); end
    n_vec++; if (evt_data !== 8'h00) begin n_err++; $display("FAIL fullpop_empty_data got %h exp 00", evt_data); end
  endtask

  task automatic test_spurious();
    bit ok;
    bus_log.delete();
    irq_force = 1'b1;
    tick();
    irq_force = 1'b0;
    wait_busy(1'b0, 20, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL spur_timeout got busy=%b exp 0", busy); end
    n_vec++; if (bus_log.size() != 1 || log_seq() !== 12'b000_000_000_011) begin n_err++; $display("FAIL spur_bus got n=%0d seq=%b exp n=1 seq=011", bus_log.size(), log_seq()); end
    n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL spur_no_event got v=%b exp 0", evt_valid); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    fire(8'h3C, 8'h77, ok);
    n_vec++; if ({ok, evt_valid} !== 2'b11) begin n_err++; $display("FAIL mid_pre got ok=%b v=%b exp 11", ok, evt_valid); end
    s_data = 8'h66; edge_set = 8'h0F;
    tick();
    edge_set = 8'h00;
    repeat (6) tick();
    n_vec++; if ({bus.avm_chipselect, bus.avm_write_n, bus.avm_address} !== 4'b1100) begin n_err++; $display("FAIL mid_in_wait_data got %b exp 1100", {bus.avm_chipselect, bus.avm_write_n, bus.avm_address}); end
    reset_n = 1'b0;
    #1;
    n_vec++; if ({bus.avm_chipselect, bus.avm_write_n, bus.avm_address, busy} !== 5'b01001) begin n_err++; $display("FAIL mid_async_out got %b exp 01001", {bus.avm_chipselect, bus.avm_write_n, bus.avm_address, busy}); end
    n_vec++; if ({evt_valid, evt_capture, bus.avm_writedata} !== 41'h0) begin n_err++; $display("FAIL mid_flush got v=%b c=%h wd=%h exp 0", evt_valid, evt_capture, bus.avm_writedata); end
    tick();
    reset_n = 1'b1;
    tick();
    n_vec++; if ({bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata} !== {4'b1010, 32'hFF}) begin n_err++; $display("FAIL mid_reinit got cs/wn/a=%b wd=%h exp 1010 ff", {bus.avm_chipselect, bus.avm_write_n, bus.avm_address}, bus.avm_writedata); end
    wait_busy(1'b0, 10, ok);
    n_vec++; if ({ok, evt_valid} !== 2'b10) begin n_err++; $display("FAIL mid_after got ok=%b v=%b exp 10", ok, evt_valid); end
  endtask

`ifdef PIO_EDGE_SERVICER_TIMESTAMP_EN
  task automatic test_timestamp();
    bit ok;
    logic [15:0] t1, t2;
    s_data = 8'h01; edge_set = 8'h01;
    tick();
    edge_set = 8'h00;
    repeat (99) tick();
    s_data = 8'h02; edge_set = 8'h02;
    tick();
    edge_set = 8'h00;
    wait_busy(1'b1, 5, ok);
    wait_busy(1'b0, 40, ok);
    t1 = evt_time;
    n_vec++; if (evt_capture !== 8'h01) begin n_err++; $display("FAIL ts_first got %h exp 01", evt_capture); end
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    t2 = evt_time;
    n_vec++; if ({evt_valid, evt_capture} !== {1'b1, 8'h02}) begin n_err++; $display("FAIL ts_second got v=%b c=%h exp v=1 c=02", evt_valid, evt_capture); end
    n_vec++; if (16'(t2 - t1) !== 16'd100) begin n_err++; $display("FAIL ts_delta got %0d exp 100", 16'(t2 - t1)); end
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_event();
    test_overflow();
    test_full_pop();
    test_spurious();
    test_reset_mid();
`ifdef PIO_EDGE_SERVICER_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
